ali3_deserializer: RTL and testbench
====================================

# ali3_deserializer

- Receive-side counterpart of the ali3_serializer AXI4-Lite peripheral; sits directly downstream of its serial output.
- Samples the framed bit stream the serializer emits and reassembles it into DATA_WIDTH-bit words.
- Buffers words in a small FIFO and presents them on an AXI4-Stream master port for the next processing stage.
- Detects and counts framing errors so software can confirm link integrity against the serializer's register writes.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per word; range 8..32.
- FIFO_DEPTH, 8, words of buffering; power of two, ≥2.
- MSB_FIRST, 1, 1 = first received bit is word MSB; 0 = LSB first.

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset; release is synchronous to ACLK externally.
- ser_data  in  1  serial data bit.
- ser_frame  in  1  high for the duration of one word frame.
- ser_bit_en  in  1  one-cycle strobe; ser_data/ser_frame sampled only when high.
- m_tdata  out  DATA_WIDTH  FIFO head word.
- m_tvalid  out  1  FIFO non-empty.
- m_tready  in  1  consumer accept.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words stored, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a completed word was dropped.
- short_err_cnt  out  8  frames ended before DATA_WIDTH(+parity) bits; saturating.
- long_err_cnt  out  8  frames with extra bits; saturating, at most +1 per frame.
- parity_err_cnt  out  8  parity mismatches; stays 0 when parity is compiled out.
- clr_err  in  1  one-cycle pulse; clears overflow and all three counters.

## Operation
- Reset: all outputs 0; FIFO empty; bit counter 0; FSM in IDLE.
- A sample is a rising edge with ser_bit_en=1; no other edge affects the shifter.

FSM:
- IDLE: sample with ser_frame=1 → capture bit, count=1, go SHIFT. Samples with ser_frame=0 are ignored.
- SHIFT: sample with ser_frame=1 → shift bit in, count+1.
  - When count reaches N (N = DATA_WIDTH, +1 with parity): push the word and go WAIT_END.
  - Sample with ser_frame=0 → short_err_cnt+1, discard the partial word, go IDLE.
- WAIT_END: sample with ser_frame=0 → go IDLE. The first sample with ser_frame=1 → long_err_cnt+1 (once per frame); further extra bits are ignored.
- A sample with ser_frame=0 that ends a frame does not start a new one. Back-to-back frames require at least one ser_frame=0 sample between them.

Bit order:
- MSB_FIRST=1: shift left; first bit ends in bit DATA_WIDTH-1.
- MSB_FIRST=0: shift right; first bit ends in bit 0.

FIFO:
- Push when full without a same-cycle pop → word dropped, overflow=1, FIFO unchanged.
- Push and pop in the same cycle at full → both happen, level unchanged, no overflow.
- Pop occurs when m_tvalid & m_tready. m_tdata is stable while m_tvalid=1 and m_tready=0.

Counters and clear:
- Counters saturate at 255.
- clr_err coincident with an error event → cleared value wins.

## Timing
- Final bit sampled at edge E → word written at E; m_tvalid=1 and fifo_level incremented in the cycle after E (1-cycle latency) when the FIFO was empty.
- Error counters and overflow update in the cycle after the offending sample.
- Reset mid-frame: the partial word is discarded, FIFO is flushed, and no error is counted.
- Throughput: one sample per cycle (ser_bit_en tied high) is supported with no bubbles.

## Configuration
- ALI3_DESER_PARITY_EN defined:
  - N = DATA_WIDTH+1; the last bit of each frame is an even-parity bit over the data bits.
  - Mismatch → word not pushed, parity_err_cnt+1.
  - A match pushes only the data bits.
- Not defined: N = DATA_WIDTH; no parity logic; parity_err_cnt tied to 0.

## Test plan
- Back-to-back streaming: MSB_FIRST=1, frames 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 with m_tready=1 → same four words out in order; all counters 0.
- Overflow: m_tready=0, send 9 frames with FIFO_DEPTH=8 → fifo_level=8, overflow=1; drain yields the first 8 words; clr_err → overflow=0.
- Short and long frames:
  - ser_frame dropped after 20 bits → short_err_cnt=1, nothing pushed.
  - 34-bit frame → first 32 bits pushed, long_err_cnt=1.
- Parity (ALI3_DESER_PARITY_EN):
  - 0xDEADBEEF with parity bit 0 → pushed.
  - Same word with parity bit 1 → parity_err_cnt=1, fifo_level unchanged.
- Full-boundary push/pop: FIFO full, m_tready=1 in the same cycle a frame completes → level stays 8, overflow=0.
- Reset mid-frame: ARESETN low after bit 10 → all outputs 0; the next full frame 0x12345678 is received correctly.

Source files
------------

// File: rtl/ali3_deserializer.sv
// Receive side of the ali3 serial link: frames serial bits into words, queues them
// in a FIFO for an AXI4-Stream master. Optional even parity: define ALI3_DESER_PARITY_EN.
module ali3_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          ser_data,
  input  logic                          ser_frame,
  input  logic                          ser_bit_en,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    short_err_cnt,
  output logic [7:0]                    long_err_cnt,
  output logic [7:0]                    parity_err_cnt,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef ALI3_DESER_PARITY_EN
  localparam int N = DATA_WIDTH + 1;
`else
  localparam int N = DATA_WIDTH;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
  localparam logic [AW:0]   FULL_C = (AW+1)'(FIFO_DEPTH);

  // WAIT_LONG remembers that this frame's extra-bit error was already counted
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END, WAIT_LONG} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]  sh, sh_nxt, shifted, push_word;
  logic                   push, short_ev, long_ev;
`ifdef ALI3_DESER_PARITY_EN
  logic                   par_ev;
`endif

  assign shifted = (MSB_FIRST != 0) ? {sh[DATA_WIDTH-2:0], ser_data}
                                    : {ser_data, sh[DATA_WIDTH-1:1]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    push_word = sh;
    push      = 1'b0;
    short_ev  = 1'b0;
    long_ev   = 1'b0;
`ifdef ALI3_DESER_PARITY_EN
    par_ev    = 1'b0;
`endif
    if (ser_bit_en) begin
      case (state)
        IDLE: if (ser_frame) begin
          sh_nxt    = shifted;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
        SHIFT: if (!ser_frame) begin
          short_ev  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt < DW_C) sh_nxt = shifted;
          if (cnt == LAST_C) begin
            cnt_nxt   = '0;
            state_nxt = WAIT_END;
`ifdef ALI3_DESER_PARITY_EN
            // sh already holds every data bit; this sample is the parity bit
            push_word = sh;
            if (ser_data != ^sh) par_ev = 1'b1;
            else                 push   = 1'b1;
`else
            push_word = shifted;
            push      = 1'b1;
`endif
          end
        end
        WAIT_END: if (!ser_frame) state_nxt = IDLE;
                  else begin
                    long_ev   = 1'b1;
                    state_nxt = WAIT_LONG;
                  end
        WAIT_LONG: if (!ser_frame) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  full, pop, wr, drop;

  assign full     = (fifo_level == FULL_C);
  assign m_tvalid = (fifo_level != '0);
  assign pop      = m_tvalid & m_tready;
  assign wr       = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign m_tdata  = m_tvalid ? mem[rptr] : '0;

  always_ff @(posedge ACLK) begin
    if (wr) mem[wptr] <= push_word;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Error reporting: clear beats a coincident event, counters saturate
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      overflow      <= 1'b0;
      short_err_cnt <= '0;
      long_err_cnt  <= '0;
    end else if (clr_err) begin
      overflow      <= 1'b0;
      short_err_cnt <= '0;
      long_err_cnt  <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (short_ev && short_err_cnt != 8'hFF) short_err_cnt <= short_err_cnt + 1'b1;
      if (long_ev && long_err_cnt != 8'hFF)   long_err_cnt  <= long_err_cnt + 1'b1;
    end
  end

`ifdef ALI3_DESER_PARITY_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                                parity_err_cnt <= '0;
    else if (clr_err)                            parity_err_cnt <= '0;
    else if (par_ev && parity_err_cnt != 8'hFF)  parity_err_cnt <= parity_err_cnt + 1'b1;
  end
`else
  assign parity_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ali3_deserializer.sv
// Scoreboard bench for ali3_deserializer: a frame-level model queues expected words,
// a negedge monitor pops and compares whenever the DUT hands a word over.
module tb_ali3_deserializer;
  localparam int DW = 32, DEPTH = 8, MSB = 1;
`ifdef ALI3_DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N = DW + PAR;

  logic          tb_ACLK = 1'b0;
  logic          ARESETN, ser_data, ser_frame, ser_bit_en, m_tready, clr_err;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, overflow;
  logic [3:0]    fifo_level;
  logic [7:0]    short_err_cnt, long_err_cnt, parity_err_cnt;

  ali3_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(MSB)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .ser_data(ser_data), .ser_frame(ser_frame),
    .ser_bit_en(ser_bit_en), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .fifo_level(fifo_level), .overflow(overflow), .short_err_cnt(short_err_cnt),
    .long_err_cnt(long_err_cnt), .parity_err_cnt(parity_err_cnt), .clr_err(clr_err));

  always #5 tb_ACLK = ~tb_ACLK;

  int            tests = 0, fails = 0;
  logic [DW-1:0] exp_q[$];
  int            m_short = 0, m_long = 0, m_par = 0;
  bit            m_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // transmitted bit i of a word, plus the trailing parity bit slot
  function automatic logic [63:0] mk_bits(input logic [DW-1:0] w, input bit pb);
    logic [63:0] b = '0;
    for (int i = 0; i < DW; i++) b[i] = (MSB != 0) ? w[DW-1-i] : w[i];
    b[DW] = pb;
    return b;
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [63:0] b);
    logic [DW-1:0] w = '0;
    for (int i = 0; i < DW; i++)
      if (MSB != 0) w[DW-1-i] = b[i]; else w[i] = b[i];
    return w;
  endfunction

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // frame reached N bits: decide drop/accept from model occupancy and this edge's pop
  task automatic model_complete(input logic [63:0] b);
    logic [DW-1:0] w = word_of(b);
    if (PAR != 0 && b[DW] != ($countones(w) % 2 == 1)) m_par = sat(m_par);
    else if (exp_q.size() < DEPTH || (exp_q.size() > 0 && m_tready)) exp_q.push_back(w);
    else m_ovf = 1'b1;
  endtask

  // rmode: 0 hold m_tready, 1 random per cycle, 2 high only on the completing bit
  task automatic send_frame(input logic [63:0] b, input int nb, input int rmode, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        @(posedge tb_ACLK); #1;
        ser_bit_en = 0; ser_frame = 1'($urandom);
        if (rmode == 1) m_tready = 1'($urandom); else if (rmode == 2) m_tready = 0;
      end
      @(posedge tb_ACLK); #1;
      ser_bit_en = 1; ser_frame = 1; ser_data = b[i];
      if (rmode == 1) m_tready = 1'($urandom); else if (rmode == 2) m_tready = (i == N-1);
      if (i == N-1) model_complete(b);
    end
    @(posedge tb_ACLK); #1;
    ser_bit_en = 1; ser_frame = 0; ser_data = 1'($urandom);
    if (rmode == 1) m_tready = 1'($urandom); else if (rmode == 2) m_tready = 0;
    if (nb < N) m_short = sat(m_short);
    else if (nb > N) m_long = sat(m_long);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge tb_ACLK); #1;
      ser_bit_en = 0; ser_frame = 0;
    end
  endtask

  task automatic check_state(input string tag);
    m_tready = 0;
    idle(2);
    @(negedge tb_ACLK);
    chk({tag, ".level"},    fifo_level, exp_q.size());
    chk({tag, ".tvalid"},   m_tvalid, exp_q.size() > 0);
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".short"},    short_err_cnt, m_short);
    chk({tag, ".long"},     long_err_cnt, m_long);
    chk({tag, ".parity"},   parity_err_cnt, m_par);
  endtask

  task automatic drain();
    int k = 0;
    m_tready = 1;
    while (exp_q.size() > 0 && k < 200) begin
      @(posedge tb_ACLK);
      k++;
    end
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
    idle(2);
    m_tready = 0;
  endtask

  task automatic pulse_clr();
    @(posedge tb_ACLK); #1 clr_err = 1;
    @(posedge tb_ACLK); #1 clr_err = 0;
    m_short = 0; m_long = 0; m_par = 0; m_ovf = 0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int rmode);
    send_frame(mk_bits(w, $countones(w) % 2 == 1), N, rmode, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tvalid"}, m_tvalid, 0);
    chk({tag, ".tdata"},  m_tdata, 0);
    chk({tag, ".level"},  fifo_level, 0);
    chk({tag, ".ovf"},    overflow, 0);
    chk({tag, ".short"},  short_err_cnt, 0);
    chk({tag, ".long"},   long_err_cnt, 0);
    chk({tag, ".par"},    parity_err_cnt, 0);
  endtask

  // scoreboard monitor
  always @(negedge tb_ACLK) begin
    if (ARESETN === 1'b1 && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_word: got %0h expected none", m_tdata);
      end else begin
        logic [DW-1:0] w;
        w = exp_q.pop_front();
        chk("tdata", m_tdata, w);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] b2b [4];
    logic [DW-1:0] w;
    b2b[0] = 32'h0101FFFF; b2b[1] = 32'hABCD0001; b2b[2] = 32'hDEAD0011; b2b[3] = 32'hBEEF0011;
    ARESETN = 0; ser_data = 0; ser_frame = 0; ser_bit_en = 0; m_tready = 0; clr_err = 0;
    repeat (3) @(posedge tb_ACLK);
    #1 chk_zero("reset");
    @(negedge tb_ACLK) ARESETN = 1;

    // back-to-back, strobe held high
    m_tready = 1;
    for (int i = 0; i < 4; i++) send_word(b2b[i], 0);
    drain();
    check_state("b2b");

    // overflow
    for (int i = 0; i < 9; i++) send_word($urandom, 0);
    check_state("ovf");
    drain();
    pulse_clr();
    check_state("ovf_clr");

    // short then long frame
    send_frame(mk_bits($urandom, 0), 20, 0, 1'b0);
    check_state("short");
    w = $urandom;
    send_frame({$urandom, $urandom}, N + 2, 0, 1'b0);
    check_state("long");
    drain();

    // full FIFO with a pop on the completing edge
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 0);
    send_word($urandom, 2);
    check_state("full_pp");
    drain();

`ifdef ALI3_DESER_PARITY_EN
    send_frame(mk_bits(32'hDEADBEEF, 0), N, 0, 1'b0);
    check_state("par_ok");
    send_frame(mk_bits(32'hDEADBEEF, 1), N, 0, 1'b0);
    check_state("par_bad");
    drain();
`endif

    // randomized traffic
    for (int f = 0; f < 40; f++) begin
      int r, nb;
      w  = $urandom;
      r  = $urandom_range(9);
      nb = (r == 0) ? $urandom_range(1, N-1) : (r == 1) ? N + $urandom_range(1, 3) : N;
      send_frame(mk_bits(w, ($countones(w) % 2 == 1) ^ ($urandom_range(7) == 0)), nb, 1, 1'b1);
    end
    drain();
    check_state("random");

    // counter saturation
    pulse_clr();
    for (int f = 0; f < 260; f++) send_frame({$urandom, $urandom}, 1, 0, 1'b0);
    check_state("sat");
    pulse_clr();
    check_state("sat_clr");

    // reset in the middle of a frame with a word queued
    send_word($urandom, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge tb_ACLK); #1;
      ser_bit_en = 1; ser_frame = 1; ser_data = 1'($urandom);
    end
    @(posedge tb_ACLK); #1;
    ARESETN = 0; ser_bit_en = 0; ser_frame = 0;
    #1 chk_zero("mid_rst");
    exp_q.delete();
    m_short = 0; m_long = 0; m_par = 0; m_ovf = 0;
    repeat (2) @(posedge tb_ACLK);
    @(negedge tb_ACLK) ARESETN = 1;
    send_word(32'h12345678, 0);
    check_state("post_rst");
    drain();
    check_state("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
